eq_biquad_stage: RTL and testbench



---
 rtl/eq_pkg.sv | 49 ++++
 rtl/eq_mac.sv | 68 ++++++
 rtl/eq_biquad_stage.sv | 171 +++++++++++++++++
 tb/tb_eq_biquad_stage.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eq_pkg
//  Description : Shared widths, coefficient addresses, FSM encoding and
//                reset coefficient set for the equalizer biquad stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 18;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = 45;

    // Coefficient register addresses; 5..7 are ignored on write
    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // Stage sequencer encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_MAC_L = 3'd2;
    localparam logic [2:0] ST_SAT_L = 3'd3;
    localparam logic [2:0] ST_MAC_R = 3'd4;
    localparam logic [2:0] ST_SAT_R = 3'd5;
    localparam logic [2:0] ST_WRITE = 3'd6;

    // Index of the last of the five MAC terms
    localparam logic [2:0] MAC_LAST = 3'd4;

    typedef struct packed {
        logic signed [COEF_W-1:0] b0;
        logic signed [COEF_W-1:0] b1;
        logic signed [COEF_W-1:0] b2;
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
    } coef_bank_t;

    // Identity filter: b0 = 1.0 in Q2.16, everything else zero
    localparam logic signed [COEF_W-1:0] COEF_UNITY = 18'sh10000;
    localparam coef_bank_t COEF_RESET = '{
        b0: COEF_UNITY, b1: '0, b2: '0, a1: '0, a2: '0
    };

endpackage : eq_pkg
`default_nettype wire

// File: rtl/eq_mac.sv
`default_nettype none
// ============================================================================
//  Module      : eq_mac
//  Description : Signed 24x18 multiply-accumulate with clear, enable and
//                subtract select, plus round-half-up / saturate output.
//  Revision    : 1.0 - initial release
// ============================================================================
module eq_mac
    import eq_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     sub_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] y_o
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX    = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN    = -(ACC_W'(1) <<< (DATA_W - 1));

    logic signed [DATA_W+COEF_W-1:0] mul_w;
    logic signed [ACC_W-1:0]         prod_w;
    logic signed [ACC_W-1:0]         base_w;
    logic signed [ACC_W-1:0]         rnd_w;
    logic signed [ACC_W-1:0]         shr_w;
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [ACC_W-1:0]         acc_d;

    assign mul_w  = data_i * coef_i;
    assign prod_w = {{(ACC_W-DATA_W-COEF_W){mul_w[DATA_W+COEF_W-1]}}, mul_w};
    assign base_w = clr_i ? '0 : acc_q;
    assign rnd_w  = acc_q + RND_HALF;
    assign shr_w  = rnd_w >>> FRAC_W;

    // Accumulate or subtract this term's product; clear restarts the sum
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = sub_i ? (base_w - prod_w) : (base_w + prod_w);
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Clamp the rounded result into the signed sample range
    always_comb begin
        if (shr_w > Y_MAX) begin
            y_o = Y_MAX[DATA_W-1:0];
        end else if (shr_w < Y_MIN) begin
            y_o = Y_MIN[DATA_W-1:0];
        end else begin
            y_o = shr_w[DATA_W-1:0];
        end
    end

endmodule : eq_mac
`default_nettype wire

// File: rtl/eq_biquad_stage.sv
`default_nettype none
// ============================================================================
//  Module      : eq_biquad_stage
//  Description : Stereo biquad between codec ADC and DAC. One shared MAC is
//                sequenced over both channels; coefficients are double-banked
//                so each sample sees one consistent set.
//  Revision    : 1.0 - initial release
// ============================================================================
module eq_biquad_stage
    import eq_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              bypass,
    output logic              busy
);

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    coef_bank_t shadow_q, active_q;
    logic       bypass_q;

    logic signed [DATA_W-1:0] x0_l_q, x1_l_q, x2_l_q, y1_l_q, y2_l_q;
    logic signed [DATA_W-1:0] x0_r_q, x1_r_q, x2_r_q, y1_r_q, y2_r_q;
    logic signed [DATA_W-1:0] wd_l_q, wd_r_q;

    logic                     mac_en_w, mac_clr_w, mac_sub_w, chan_r_w;
    logic signed [DATA_W-1:0] mac_data_w;
    logic signed [COEF_W-1:0] mac_coef_w;
    logic signed [DATA_W-1:0] mac_y_w;

    assign read            = (state_q == ST_READ);
    assign write           = (state_q == ST_WRITE) && write_ready;
    assign busy            = (state_q != ST_IDLE);
    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;

    assign chan_r_w  = (state_q == ST_MAC_R);
    assign mac_en_w  = (state_q == ST_MAC_L) || (state_q == ST_MAC_R);
    assign mac_clr_w = (cnt_q == 3'd0);
    assign mac_sub_w = (cnt_q == COEF_A1) || (cnt_q == COEF_A2);

    // Sequencer: five MAC cycles and one saturate cycle per channel
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:  if (read_ready) state_d = ST_READ;
            ST_READ: begin
                state_d = ST_MAC_L;
                cnt_d   = '0;
            end
            ST_MAC_L: begin
                if (cnt_q == MAC_LAST) begin
                    state_d = ST_SAT_L;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SAT_L: state_d = ST_MAC_R;
            ST_MAC_R: begin
                if (cnt_q == MAC_LAST) begin
                    state_d = ST_SAT_R;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SAT_R: state_d = ST_WRITE;
            ST_WRITE: if (write_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pick the operand pair for the current term of the active channel
    always_comb begin
        mac_data_w = '0;
        mac_coef_w = '0;
        case (cnt_q)
            3'd0: begin mac_data_w = chan_r_w ? x0_r_q : x0_l_q; mac_coef_w = active_q.b0; end
            3'd1: begin mac_data_w = chan_r_w ? x1_r_q : x1_l_q; mac_coef_w = active_q.b1; end
            3'd2: begin mac_data_w = chan_r_w ? x2_r_q : x2_l_q; mac_coef_w = active_q.b2; end
            3'd3: begin mac_data_w = chan_r_w ? y1_r_q : y1_l_q; mac_coef_w = active_q.a1; end
            3'd4: begin mac_data_w = chan_r_w ? y2_r_q : y2_l_q; mac_coef_w = active_q.a2; end
            default: ;
        endcase
    end

    eq_mac u_mac (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .clr_i  (mac_clr_w),
        .en_i   (mac_en_w),
        .sub_i  (mac_sub_w),
        .data_i (mac_data_w),
        .coef_i (mac_coef_w),
        .y_o    (mac_y_w)
    );

    // Sequencer state registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Coefficient banks, sample capture, history shift and output registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= COEF_RESET;
            active_q <= COEF_RESET;
            bypass_q <= 1'b0;
            x0_l_q <= '0; x1_l_q <= '0; x2_l_q <= '0; y1_l_q <= '0; y2_l_q <= '0;
            x0_r_q <= '0; x1_r_q <= '0; x2_r_q <= '0; y1_r_q <= '0; y2_r_q <= '0;
            wd_l_q <= '0;
            wd_r_q <= '0;
        end else begin
            if (coef_we) begin
                case (coef_addr)
                    COEF_B0: shadow_q.b0 <= coef_data;
                    COEF_B1: shadow_q.b1 <= coef_data;
                    COEF_B2: shadow_q.b2 <= coef_data;
                    COEF_A1: shadow_q.a1 <= coef_data;
                    COEF_A2: shadow_q.a2 <= coef_data;
                    default: ;
                endcase
            end
            case (state_q)
                ST_READ: begin
                    x0_l_q   <= readdata_left;
                    x0_r_q   <= readdata_right;
                    bypass_q <= bypass;
                    active_q <= shadow_q;
                end
                ST_SAT_L: begin
                    x2_l_q <= x1_l_q;
                    x1_l_q <= x0_l_q;
                    y2_l_q <= y1_l_q;
                    y1_l_q <= mac_y_w;
                    wd_l_q <= bypass_q ? x0_l_q : mac_y_w;
                end
                ST_SAT_R: begin
                    x2_r_q <= x1_r_q;
                    x1_r_q <= x0_r_q;
                    y2_r_q <= y1_r_q;
                    y1_r_q <= mac_y_w;
                    wd_r_q <= bypass_q ? x0_r_q : mac_y_w;
                end
                default: ;
            endcase
        end
    end

endmodule : eq_biquad_stage
`default_nettype wire

// File: tb/tb_eq_biquad_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eq_biquad_stage
//  Description : Self-checking bench for eq_biquad_stage. A behavioural
//                biquad model fills a scoreboard when a sample is read; the
//                queue is popped and compared on each write pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_biquad_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_ready;
    logic [23:0] readdata_left, readdata_right;
    logic        read;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left, writedata_right;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [17:0] coef_data;
    logic        bypass;
    logic        busy;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int read_cyc = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;
    exp_t sb_q[$];

    longint m_sh[5], m_ac[5];
    longint m_x1[2], m_x2[2], m_y1[2], m_y2[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eq_biquad_stage dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .bypass          (bypass),
        .busy            (busy)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh[i] = 0;
            m_ac[i] = 0;
        end
        m_sh[0] = 65536;
        m_ac[0] = 65536;
        for (int c = 0; c < 2; c++) begin
            m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
        end
    endfunction

    function automatic logic [23:0] model_chan(input int ch, input logic [23:0] xin, input logic byp);
        longint x0, acc, y;
        logic [23:0] res;
        x0  = longint'($signed(xin));
        acc = m_ac[0] * x0 + m_ac[1] * m_x1[ch] + m_ac[2] * m_x2[ch]
            - m_ac[3] * m_y1[ch] - m_ac[4] * m_y2[ch];
        y = (acc + 64'sd32768) >>> 16;
        if (y > 64'sd8388607)       y = 64'sd8388607;
        else if (y < -64'sd8388608) y = -64'sd8388608;
        m_x2[ch] = m_x1[ch];
        m_x1[ch] = x0;
        m_y2[ch] = m_y1[ch];
        m_y1[ch] = y;
        res = byp ? xin : y[23:0];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [17:0] data);
        logic [17:0] d;
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        d = data;
        if (addr < 3'd5) m_sh[addr] = longint'($signed(d));
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offer one sample pair and wait for the read pulse; model runs on read
    task automatic send(input logic [23:0] l, input logic [23:0] r, input logic byp);
        bit got;
        got = 1'b0;
        @(negedge clk);
        readdata_left  = l;
        readdata_right = r;
        bypass         = byp;
        read_ready     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (read === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL read_handshake: read=%b, required 1 within 50 cycles", read);
        end else begin
            exp_t e;
            for (int k = 0; k < 5; k++) m_ac[k] = m_sh[k];
            e.l = model_chan(0, l, byp);
            e.r = model_chan(1, r, byp);
            sb_q.push_back(e);
            read_cyc = cyc;
        end
        read_ready = 1'b0;
    endtask

    // Wait for the write pulse, pop the scoreboard and compare
    task automatic collect(input bit chk_lat, input string name);
        bit   got;
        bit   extra_read;
        int   lat;
        exp_t e;
        got        = 1'b0;
        extra_read = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (write === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (i > 0 && read !== 1'b0) extra_read = 1'b1;
            @(negedge clk);
        end
        compared++;
        if (extra_read !== 1'b0) begin
            failed++;
            $display("FAIL %s_no_read_while_busy: extra read seen=%b, required 0", name, extra_read);
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL %s_write_timeout: write=%b, required 1 within 300 cycles", name, write);
        end else if (sb_q.size() == 0) begin
            failed++;
            $display("FAIL %s_scoreboard: queue size 0, required at least 1", name);
        end else begin
            lat = cyc - read_cyc;
            e   = sb_q.pop_front();
            compared++;
            if (writedata_left !== e.l) begin
                failed++;
                $display("FAIL %s_left: got %h, required %h", name, writedata_left, e.l);
            end
            compared++;
            if (writedata_right !== e.r) begin
                failed++;
                $display("FAIL %s_right: got %h, required %h", name, writedata_right, e.r);
            end
            if (chk_lat) begin
                compared++;
                if (lat !== 13) begin
                    failed++;
                    $display("FAIL %s_latency: got %0d, required 13", name, lat);
                end
            end
            @(negedge clk);
            compared++;
            if (write !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL %s_single_pulse: write=%b busy=%b, required 0 0", name, write, busy);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        compared++;
        if ({read, write, busy} !== 3'b000) begin
            failed++;
            $display("FAIL reset_ctrl: read/write/busy=%b, required 000", {read, write, busy});
        end
        compared++;
        if ({writedata_left, writedata_right} !== 48'h0) begin
            failed++;
            $display("FAIL reset_data: got %h, required 0", {writedata_left, writedata_right});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    task automatic test_identity();
        send(24'h123456, 24'hFEDCBA, 1'b0);
        collect(1'b1, "identity");
    endtask

    task automatic test_gain_round();
        write_coef(3'd0, 18'h08000);
        send(24'd3, -24'sd3, 1'b0);
        collect(1'b1, "gain_half");
    endtask

    task automatic test_bypass();
        send(24'h000101, 24'hFFFF01, 1'b1);
        collect(1'b1, "bypass");
    endtask

    task automatic test_saturation();
        write_coef(3'd0, 18'h1FFFF);
        send(24'h7FFFFF, 24'h800000, 1'b0);
        collect(1'b1, "saturate");
    endtask

    task automatic test_delay_line();
        do_reset();
        write_coef(3'd0, 18'h00000);
        write_coef(3'd1, 18'h10000);
        send(24'd10, 24'd7, 1'b0);
        collect(1'b0, "delay0");
        send(24'd20, -24'sd8, 1'b0);
        collect(1'b0, "delay1");
        send(24'd30, 24'd9, 1'b0);
        collect(1'b0, "delay2");
    endtask

    task automatic test_backpressure();
        bit bad_ctrl, bad_data;
        do_reset();
        write_ready = 1'b0;
        send(24'h0ABCDE, 24'h765432, 1'b0);
        repeat (13) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            bad_ctrl = (write !== 1'b0) || (read !== 1'b0) || (busy !== 1'b1);
            bad_data = (writedata_left !== sb_q[0].l) || (writedata_right !== sb_q[0].r);
            compared++;
            if (bad_ctrl) begin
                failed++;
                $display("FAIL bp_ctrl: write/read/busy=%b%b%b, required 001", write, read, busy);
            end
            compared++;
            if (bad_data) begin
                failed++;
                $display("FAIL bp_hold: got %h %h, required %h %h",
                         writedata_left, writedata_right, sb_q[0].l, sb_q[0].r);
            end
            @(negedge clk);
        end
        write_ready = 1'b1;
        #1;
        collect(1'b0, "bp_release");
    endtask

    task automatic test_coef_while_busy();
        do_reset();
        send(24'd100, -24'sd100, 1'b0);
        repeat (2) @(negedge clk);
        write_coef(3'd0, 18'h08000);
        collect(1'b1, "coef_old");
        send(24'd100, -24'sd100, 1'b0);
        collect(1'b1, "coef_new");
    endtask

    task automatic test_reset_mid_mac();
        bit saw_write;
        write_coef(3'd0, 18'h08000);
        send(24'd1000, 24'd2000, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        compared++;
        if ({write, busy, read} !== 3'b000) begin
            failed++;
            $display("FAIL midrst_ctrl: write/busy/read=%b, required 000", {write, busy, read});
        end
        compared++;
        if ({writedata_left, writedata_right} !== 48'h0) begin
            failed++;
            $display("FAIL midrst_data: got %h, required 0", {writedata_left, writedata_right});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        sb_q.delete();
        saw_write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (write !== 1'b0) saw_write = 1'b1;
        end
        compared++;
        if (saw_write !== 1'b0) begin
            failed++;
            $display("FAIL midrst_no_write: saw write=%b, required 0", saw_write);
        end
        send(24'h000100, 24'hFFFF00, 1'b0);
        collect(1'b1, "midrst_identity");
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_coef(3'd0, 18'h04000);
        write_coef(3'd1, 18'h08000);
        write_coef(3'd2, 18'h04000);
        write_coef(3'd3, 18'h36000);
        write_coef(3'd4, 18'h03000);
        write_coef(3'd6, 18'h1FFFF);
        for (int i = 0; i < 8; i++) begin
            send(24'($urandom), 24'($urandom), 1'b0);
            collect(1'b1, "b2b");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b1;
        read_ready     = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        write_ready    = 1'b1;
        coef_we        = 1'b0;
        coef_addr      = '0;
        coef_data      = '0;
        bypass         = 1'b0;
        model_reset();

        test_reset();
        test_identity();
        test_gain_round();
        test_bypass();
        test_saturation();
        test_delay_line();
        test_backpressure();
        test_coef_while_busy();
        test_reset_mid_mac();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule : tb_eq_biquad_stage
`default_nettype wire
